// File: rtl/popcount_acc_if.sv
// -----------------------------------------------------------------------------
// popcount_acc_if
// Beat-input / group-result handshake bundle for popcount_acc.
//
// Signals:
//   din        data beat
//   din_mask   1 = bit is counted, 0 = bit ignored
//   din_zero   1 = count masked zeros, 0 = count masked ones (per beat)
//   din_last   final beat of a group
//   din_vld    beat valid                      (master -> slave)
//   din_rdy    block can accept a beat         (slave  -> master)
//   dout       group total
//   dout_beats number of beats in the group
//   dout_sat   group total clamped (saturating build only, else 0)
//   dout_vld   result valid                    (slave  -> master)
//   dout_rdy   downstream accepts the result   (master -> slave)
//
// Modports: master = beat producer / result consumer, slave = popcount_acc.
// -----------------------------------------------------------------------------
interface popcount_acc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_BIT    = 16,
    parameter int BEAT_BIT   = 8
) ();

    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] din_mask;
    logic                  din_zero;
    logic                  din_last;
    logic                  din_vld;
    logic                  din_rdy;
    logic [ACC_BIT-1:0]    dout;
    logic [BEAT_BIT-1:0]   dout_beats;
    logic                  dout_sat;
    logic                  dout_vld;
    logic                  dout_rdy;

    modport master (
        output din, din_mask, din_zero, din_last, din_vld, dout_rdy,
        input  din_rdy, dout, dout_beats, dout_sat, dout_vld
    );

    modport slave (
        input  din, din_mask, din_zero, din_last, din_vld, dout_rdy,
        output din_rdy, dout, dout_beats, dout_sat, dout_vld
    );

endinterface : popcount_acc_if

// File: rtl/popcount_acc.sv
// -----------------------------------------------------------------------------
// popcount_acc
// Pipelined masked population counter with multi-beat group accumulation.
// Each accepted beat is reduced by a registered binary adder tree (LEVELS
// register stages); per-beat counts are summed until a beat flagged din_last,
// then one registered total per group is presented with valid/ready.
//
// Parameters:
//   DATA_WIDTH  bits per beat (>= 2)
//   ACC_BIT     accumulator / result width (>= COUNT_BIT)
//   BEAT_BIT    beat-counter width (wraps)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards all in-flight state
//   bus    popcount_acc_if.slave (din*, dout*, handshakes)
//
// Optional build macro: POPCOUNT_ACC_SAT_EN
//   defined   : accumulator/total clamp at 2^ACC_BIT-1, dout_sat flags a clamp
//   undefined : accumulator/total wrap modulo 2^ACC_BIT, dout_sat tied to 0
// -----------------------------------------------------------------------------
module popcount_acc #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_BIT    = 16,
    parameter int BEAT_BIT   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    popcount_acc_if.slave  bus
);

    localparam int COUNT_BIT = $clog2(DATA_WIDTH + 1);
    localparam int LEVELS    = $clog2(DATA_WIDTH);
    // Operand arrays are padded to twice the width so that pair indices
    // 2i and 2i+1 always stay in range; padding entries are constant zero,
    // which also makes odd leftovers pass through as "leftover + 0".
    localparam int NW        = 2 * DATA_WIDTH;

    logic                  en_s;
    logic [DATA_WIDTH-1:0] bits_s;
    logic [COUNT_BIT-1:0]  src_s  [LEVELS][NW];
    logic [COUNT_BIT-1:0]  tree_r [LEVELS][DATA_WIDTH];
    logic [LEVELS-1:0]     vld_r;
    logic [LEVELS-1:0]     last_r;
    logic [ACC_BIT-1:0]    cnt_s;
    logic [ACC_BIT-1:0]    acc_r;
    logic [ACC_BIT-1:0]    acc_nxt_s;
    logic [BEAT_BIT-1:0]   beats_r;
    logic [BEAT_BIT-1:0]   beats_nxt_s;
    logic [ACC_BIT-1:0]    dout_r;
    logic [BEAT_BIT-1:0]   dout_beats_r;
    logic                  dout_vld_r;

    // Whole pipeline advances only when the output slot is free or draining.
    assign en_s        = !dout_vld_r || bus.dout_rdy;
    assign bus.din_rdy = en_s && rst_n;

    assign bits_s = (bus.din_zero ? ~bus.din : bus.din) & bus.din_mask;

    assign bus.dout       = dout_r;
    assign bus.dout_beats = dout_beats_r;
    assign bus.dout_vld   = dout_vld_r;

    // Operand view of every tree level: level 0 is the selected bits, level
    // k>0 is the register bank of stage k; the padding is held at zero.
    always_comb begin
        for (int k = 0; k < LEVELS; k++) begin
            for (int i = 0; i < NW; i++) begin
                src_s[k][i] = '0;
            end
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            src_s[0][i] = COUNT_BIT'(bits_s[i]);
        end
        for (int k = 1; k < LEVELS; k++) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                src_s[k][i] = tree_r[k-1][i];
            end
        end
    end

    // Adder-tree register stages with valid/last sidebands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LEVELS; k++) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    tree_r[k][i] <= '0;
                end
            end
            vld_r  <= '0;
            last_r <= '0;
        end else if (en_s) begin
            for (int k = 0; k < LEVELS; k++) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    // Partial sums never exceed DATA_WIDTH, so COUNT_BIT holds them.
                    tree_r[k][i] <= src_s[k][2*i] + src_s[k][2*i+1];
                end
            end
            vld_r[0]  <= bus.din_vld;
            last_r[0] <= bus.din_last;
            for (int k = 1; k < LEVELS; k++) begin
                vld_r[k]  <= vld_r[k-1];
                last_r[k] <= last_r[k-1];
            end
        end
    end

    assign cnt_s       = ACC_BIT'(tree_r[LEVELS-1][0]);
    assign beats_nxt_s = beats_r + BEAT_BIT'(1);

`ifdef POPCOUNT_ACC_SAT_EN
    logic [ACC_BIT:0] sum_full_s;
    logic             ovf_s;
    logic             sat_r;
    logic             dout_sat_r;

    // Saturating add: a carry out clamps the running total to all ones.
    always_comb begin
        sum_full_s = {1'b0, acc_r} + {1'b0, cnt_s};
        ovf_s      = sum_full_s[ACC_BIT];
        if (ovf_s) begin
            acc_nxt_s = '1;
        end else begin
            acc_nxt_s = sum_full_s[ACC_BIT-1:0];
        end
    end

    // Sticky clamp flag for the current group, published with the total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r      <= 1'b0;
            dout_sat_r <= 1'b0;
        end else if (en_s && vld_r[LEVELS-1]) begin
            if (last_r[LEVELS-1]) begin
                dout_sat_r <= sat_r | ovf_s;
                sat_r      <= 1'b0;
            end else begin
                sat_r      <= sat_r | ovf_s;
            end
        end
    end

    assign bus.dout_sat = dout_sat_r;
`else
    // Wrapping add.
    always_comb begin
        acc_nxt_s = acc_r + cnt_s;
    end

    assign bus.dout_sat = 1'b0;
`endif

    // Group accumulator and registered result slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r        <= '0;
            beats_r      <= '0;
            dout_r       <= '0;
            dout_beats_r <= '0;
            dout_vld_r   <= 1'b0;
        end else if (en_s) begin
            if (vld_r[LEVELS-1]) begin
                if (last_r[LEVELS-1]) begin
                    // Close the group; clearing here lets the next beat start fresh.
                    dout_r       <= acc_nxt_s;
                    dout_beats_r <= beats_nxt_s;
                    dout_vld_r   <= 1'b1;
                    acc_r        <= '0;
                    beats_r      <= '0;
                end else begin
                    acc_r        <= acc_nxt_s;
                    beats_r      <= beats_nxt_s;
                    dout_vld_r   <= 1'b0;
                end
            end else begin
                dout_vld_r <= 1'b0;
            end
        end
    end

endmodule : popcount_acc

// File: tb/tb_popcount_acc.sv
// -----------------------------------------------------------------------------
// tb_popcount_acc
// Directed and randomized bench for popcount_acc (DATA_WIDTH=8, ACC_BIT=6,
// BEAT_BIT=4). A group-level reference model computes expected totals from
// per-beat popcounts with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_popcount_acc;

    localparam int DW      = 8;
    localparam int AB      = 6;
    localparam int BB      = 4;
    localparam int ACC_MAX = (1 << AB) - 1;

    typedef struct {
        int tot;
        int beats;
        int sat;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    popcount_acc_if #(.DATA_WIDTH(DW), .ACC_BIT(AB), .BEAT_BIT(BB)) bus ();

    popcount_acc #(.DATA_WIDTH(DW), .ACC_BIT(AB), .BEAT_BIT(BB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    res_t exp_q[$];
    int   pop_cyc_q[$];
    int   m_acc;
    int   m_beats;
    int   m_sat;
    bit   acc_seen;
    bit   vld_seen;
    bit   rand_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc   = 0;
        m_beats = 0;
        m_sat   = 0;
    endtask

    // Reference: per-beat popcount added into the group total.
    task automatic model_beat(input logic [DW-1:0] d, input logic [DW-1:0] m,
                              input logic z, input logic l);
        logic [DW-1:0] sel;
        res_t r;
        sel = (z ? ~d : d) & m;
        m_acc += $countones(sel);
`ifdef POPCOUNT_ACC_SAT_EN
        if (m_acc > ACC_MAX) begin
            m_acc = ACC_MAX;
            m_sat = 1;
        end
`else
        m_acc = m_acc % (ACC_MAX + 1);
`endif
        m_beats = (m_beats + 1) % (1 << BB);
        if (l) begin
            r.tot   = m_acc;
            r.beats = m_beats;
            r.sat   = m_sat;
            exp_q.push_back(r);
            model_clear();
        end
    endtask

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic clk_cycle();
        res_t r;
        @(negedge clk);
        cyc++;
        acc_seen = bus.din_vld && bus.din_rdy;
        vld_seen = bus.dout_vld;
        if (acc_seen) model_beat(bus.din, bus.din_mask, bus.din_zero, bus.din_last);
        if (!rst_n) begin
            check("rst_dout",       32'(bus.dout),       32'd0);
            check("rst_dout_beats", 32'(bus.dout_beats), 32'd0);
            check("rst_dout_sat",   32'(bus.dout_sat),   32'd0);
            check("rst_dout_vld",   32'(bus.dout_vld),   32'd0);
            check("rst_din_rdy",    32'(bus.din_rdy),    32'd0);
        end else if (bus.dout_vld) begin
            if (exp_q.size() == 0) begin
                check("spurious_vld", 32'(bus.dout_vld), 32'd0);
            end else begin
                r = exp_q[0];
                check("dout",       32'(bus.dout),       32'(r.tot));
                check("dout_beats", 32'(bus.dout_beats), 32'(r.beats));
                check("dout_sat",   32'(bus.dout_sat),   32'(r.sat));
                if (bus.dout_rdy) begin
                    void'(exp_q.pop_front());
                    pop_cyc_q.push_back(cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        if (rand_rdy) bus.dout_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DW-1:0] m,
                             input logic z, input logic l);
        bus.din      = d;
        bus.din_mask = m;
        bus.din_zero = z;
        bus.din_last = l;
        bus.din_vld  = 1'b1;
        for (int t = 0; t < 100; t++) begin
            clk_cycle();
            if (acc_seen) break;
        end
        if (!acc_seen) check("accept_timeout", 32'(acc_seen), 32'd1);
        bus.din_vld = 1'b0;
    endtask

    task automatic drain();
        bus.din_vld = 1'b0;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) clk_cycle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (6) clk_cycle();
    endtask

    task automatic do_reset();
        bus.din_vld = 1'b0;
        rst_n = 1'b0;
        model_clear();
        exp_q.delete();
        repeat (3) clk_cycle();
        rst_n = 1'b1;
        clk_cycle();
        check("rdy_after_rst", 32'(bus.din_rdy), 32'd1);
    endtask

    initial begin
        int lat;
        int len;
        logic [DW-1:0] d;
        logic [DW-1:0] m;

        bus.din      = '0;
        bus.din_mask = '0;
        bus.din_zero = 1'b0;
        bus.din_last = 1'b0;
        bus.din_vld  = 1'b0;
        bus.dout_rdy = 1'b1;
        rand_rdy     = 1'b0;
        rst_n        = 1'b0;
        model_clear();
        #2;
        do_reset();

        // Single full beat and its latency.
        bus.din      = 8'hFF;
        bus.din_mask = 8'hFF;
        bus.din_zero = 1'b0;
        bus.din_last = 1'b1;
        bus.din_vld  = 1'b1;
        clk_cycle();
        check("t1_accept", 32'(acc_seen), 32'd1);
        bus.din_vld = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            clk_cycle();
            if (vld_seen && lat < 0) lat = k;
        end
        check("t1_latency", 32'(lat), 32'd4);
        drain();

        // Three-beat group.
        send_beat(8'h0F, 8'hFF, 1'b0, 1'b0);
        send_beat(8'h03, 8'hFF, 1'b0, 1'b0);
        send_beat(8'h01, 8'hFF, 1'b0, 1'b1);
        drain();

        // Mask with zero counting.
        send_beat(8'hF0, 8'h3C, 1'b1, 1'b1);
        drain();

        // Nine full beats overflow a 6-bit total.
        for (int b = 0; b < 9; b++) send_beat(8'hFF, 8'hFF, 1'b0, (b == 8));
        drain();

        // Empty mask still counts as a beat.
        send_beat(8'hA5, 8'h00, 1'b0, 1'b0);
        send_beat(8'hA5, 8'h00, 1'b1, 1'b1);
        drain();

        // Backpressure: results pile up, input must stall, then all drain in order.
        bus.dout_rdy = 1'b0;
        send_beat(8'h01, 8'hFF, 1'b0, 1'b1);
        send_beat(8'h07, 8'hFF, 1'b0, 1'b1);
        send_beat(8'h3F, 8'hFF, 1'b0, 1'b1);
        repeat (3) clk_cycle();
        for (int k = 0; k < 4; k++) begin
            clk_cycle();
            check("stall_din_rdy", 32'(bus.din_rdy), 32'd0);
        end
        bus.dout_rdy = 1'b1;
        drain();

        // Back-to-back single-beat groups give results on consecutive cycles.
        pop_cyc_q.delete();
        for (int g = 0; g < 4; g++) send_beat(8'(g + 1), 8'hFF, 1'b0, 1'b1);
        drain();
        check("b2b_count", 32'(pop_cyc_q.size()), 32'd4);
        for (int i = 1; i < pop_cyc_q.size(); i++)
            check("b2b_spacing", 32'(pop_cyc_q[i] - pop_cyc_q[i-1]), 32'd1);

        // Reset in the middle of a group discards it.
        send_beat(8'hFF, 8'hFF, 1'b0, 1'b0);
        send_beat(8'hFF, 8'hFF, 1'b0, 1'b0);
        do_reset();
        send_beat(8'h01, 8'hFF, 1'b0, 1'b1);
        drain();

        // Randomized groups under random backpressure.
        rand_rdy = 1'b1;
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 10);
            for (int b = 0; b < len; b++) begin
                d = 8'($urandom);
                m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                send_beat(d, m, 1'($urandom_range(0, 1)), (b == len - 1));
            end
        end
        rand_rdy     = 1'b0;
        bus.dout_rdy = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_popcount_acc
